ovl_multi_checker: RTL and testbench
====================================

OVL_MULTI_CHECKER -- requirements
Module: ovl_multi_checker

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 4, giving the number of independent checker channels (1..16).
REQ-002 The block SHALL take parameter CKS_W, default 3, giving the width of each channel's num_cks field.
REQ-003 The block SHALL take parameter CNT_W, default 8, giving the width of the saturating fire counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
REQ-005 The block SHALL have the following other ports:
- enable  in  1  global advance/qualify
- clear  in  1  synchronous clear of sticky and count
- num_cks  in  NUM_CH*CKS_W  per-channel cycle distance, channel i at [i*CKS_W +: CKS_W]
- start_event  in  NUM_CH  per-channel trigger
- test_expr  in  NUM_CH  per-channel checked expression
- select  in  2*NUM_CH  per-channel mode, channel i at [2i +: 2]
- prev_config_invalid  in  1  invalid flag from the upstream fabric stage
- fire  out  NUM_CH  combinational per-channel failure
- fire_delayed  out  NUM_CH  fire registered one cycle
- fire_sticky  out  NUM_CH  latched failure per channel
- any_fire  out  1  OR of fire
- fire_count  out  CNT_W  saturating count of cycles with any_fire
- config_invalid  out  1  chained configuration error

Function
REQ-006 Mode encodings SHALL be as follows; NEXT and WINDOW use a timed check, ALWAYS and NEVER are untimed:
- 2'b00 NEXT: test_expr must be 1 exactly num_cks cycles after start_event.
- 2'b01 WINDOW: test_expr must be 1 in at least one of cycles 1..num_cks after start_event.
- 2'b10 ALWAYS: test_expr must be 1 every enabled cycle.
- 2'b11 NEVER: test_expr must be 0 every enabled cycle.
REQ-007 A channel SHALL be invalid when num_cks==0 and select[1]==0, and config_invalid SHALL be the OR of prev_config_invalid and every channel's invalid flag.
REQ-008 An invalid channel SHALL hold fire=0 and keep its FSM in IDLE.
REQ-009 Each timed channel SHALL run an FSM with two states, IDLE and ARMED, plus a down-counter of width CKS_W.
REQ-010 In IDLE, with enable=1, start_event=1 and the channel valid, the FSM SHALL load the counter with num_cks and go to ARMED on the next edge.
REQ-011 In ARMED with enable=1 the counter SHALL decrement each cycle, and the check cycle SHALL be the cycle in which the counter equals 1.
REQ-012 In NEXT mode, fire SHALL equal ~test_expr combinationally in the check cycle and SHALL be 0 in all other cycles.
REQ-013 In WINDOW mode, a test_expr=1 in ARMED SHALL return the FSM to IDLE without firing.
REQ-014 In WINDOW mode, if test_expr=0 in the check cycle and it never went high earlier in the window, fire SHALL be 1 in that check cycle.
REQ-015 After the check cycle the FSM SHALL return to IDLE.
REQ-016 A start_event arriving while ARMED SHALL be ignored; checks do not overlap and do not restart.
REQ-017 A start_event in the same cycle as the check cycle SHALL be ignored; re-arm needs an IDLE cycle.
REQ-018 With enable=0, the FSM and counter SHALL freeze; fire, fire_delayed, the sticky bits and fire_count SHALL hold, except that fire is forced to 0.
REQ-019 A mode or num_cks change while ARMED SHALL take effect at the next arm; the counter is not reloaded.
REQ-020 In ALWAYS and NEVER modes, fire SHALL be combinational on test_expr&enable, and the FSM SHALL stay in IDLE.
REQ-021 fire_delayed[i] SHALL capture fire[i] on each edge with enable=1.
REQ-022 fire_sticky[i] SHALL set on fire[i] and clear only on clear=1 or on rst.
REQ-023 If clear and fire[i] are both 1 in the same cycle, set SHALL win.
REQ-024 fire_count SHALL increment by 1 per cycle with any_fire=1 and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-025 clear SHALL zero fire_count; if any_fire is also 1 in that cycle, fire_count SHALL load 1.

Reset
REQ-026 On rst=1, asynchronously, the block SHALL force all FSMs to IDLE and set counters=0, fire_delayed=0, fire_sticky=0 and fire_count=0.
REQ-027 fire, any_fire and config_invalid SHALL remain combinational, with fire held 0 during reset.
REQ-028 A reset asserted mid-check SHALL abort the check with no fire.

Structure
REQ-029 The mode encodings, the IDLE/ARMED state encoding and the parameter defaults SHALL live in the shared package ovl_pkg.
REQ-030 Per-channel logic (FSM, counter and fire decode) SHALL be the sub-module ovl_check_ch, instantiated NUM_CH times by generate.
REQ-031 The sticky bits, fire_count and the config_invalid reduction SHALL live in the top level.

Verification
REQ-032 Bench scenario NEXT pass: ch0 select=00, num_cks=3, start at t0, test_expr=1 only at t3 -> fire never 1, fire_count=0.
REQ-033 Bench scenario NEXT fail: the same stimulus with test_expr=0 at t3 -> fire[0]=1 at t3 only, fire_delayed[0]=1 at t4, fire_sticky[0]=1, fire_count=1.
REQ-034 Bench scenario WINDOW: select=01, num_cks=4, test_expr=1 at t2 -> no fire and IDLE at t3; repeating with test_expr low through t4 -> fire at t4.
REQ-035 Bench scenario config: num_cks=0, select=00, prev_config_invalid=0 -> config_invalid=1 and fire=0 despite start; switching select to 10 -> config_invalid=0.
REQ-036 Bench scenario saturation and clear: CNT_W=3, NEVER mode with test_expr=1 for 10 cycles -> fire_count=7; clear with fire=1 -> fire_count=1, sticky stays 1.
REQ-037 Bench scenario enable and reset: enable=0 for 2 cycles mid-window extends the check by 2 cycles; rst pulsed mid-ARMED -> IDLE immediately, no fire, all registers 0.

Source files
------------

// File: rtl/ovl_pkg.sv
// Shared definitions for the multi-channel OVL checker: mode and state
// encodings, parameter defaults and a small mode-decode helper.
package ovl_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CKS_W  = 3;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    MODE_NEXT   = 2'b00,
    MODE_WINDOW = 2'b01,
    MODE_ALWAYS = 2'b10,
    MODE_NEVER  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // NEXT and WINDOW need the armed/count sequence; ALWAYS and NEVER do not.
  function automatic logic is_timed(input mode_e mode);
    return (mode == MODE_NEXT) || (mode == MODE_WINDOW);
  endfunction

endpackage

// File: rtl/ovl_multi_checker_if.sv
// Bundles the checker's stimulus and result signals; master drives the
// checked design's view, slave is the checker itself.
interface ovl_multi_checker_if
  import ovl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CKS_W  = DEF_CKS_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic                    enable;
  logic                    clear;
  logic [NUM_CH*CKS_W-1:0] num_cks;
  logic [NUM_CH-1:0]       start_event;
  logic [NUM_CH-1:0]       test_expr;
  logic [2*NUM_CH-1:0]     select;
  logic                    prev_config_invalid;
  logic [NUM_CH-1:0]       fire;
  logic [NUM_CH-1:0]       fire_delayed;
  logic [NUM_CH-1:0]       fire_sticky;
  logic                    any_fire;
  logic [CNT_W-1:0]        fire_count;
  logic                    config_invalid;

  modport master (
    output enable, clear, num_cks, start_event, test_expr, select, prev_config_invalid,
    input  fire, fire_delayed, fire_sticky, any_fire, fire_count, config_invalid
  );

  modport slave (
    input  enable, clear, num_cks, start_event, test_expr, select, prev_config_invalid,
    output fire, fire_delayed, fire_sticky, any_fire, fire_count, config_invalid
  );
endinterface

// File: rtl/ovl_check_ch.sv
// One checker channel: IDLE/ARMED FSM with a down-counter for the timed
// modes, plus the combinational fire decode for all four modes.
module ovl_check_ch
  import ovl_pkg::*;
#(
  parameter int CKS_W = DEF_CKS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CKS_W-1:0] num_cks,
  input  logic             start_event,
  input  logic             test_expr,
  input  logic [1:0]       select,
  output logic             fire,
  output logic             invalid
);

  localparam logic [CKS_W-1:0] CNT_ZERO = {CKS_W{1'b0}};
  localparam logic [CKS_W-1:0] CNT_ONE  = CKS_W'(1);

  state_e           state_r, state_nxt_s;
  mode_e            mode_r, mode_nxt_s;
  mode_e            cur_mode_s;
  logic [CKS_W-1:0] cnt_r, cnt_nxt_s;
  logic             check_s;
  logic             fire_s;

  assign cur_mode_s = mode_e'(select);
  assign invalid    = (num_cks == CNT_ZERO) && !select[1];
  assign check_s    = (cnt_r == CNT_ONE);
  assign fire       = fire_s & ~rst;

  // Next-state, counter and fire decode; the mode in force while armed is the one latched at arm time.
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    cnt_nxt_s   = cnt_r;
    fire_s      = 1'b0;
    if (invalid) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else if (!enable) begin
      fire_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!is_timed(cur_mode_s)) begin
            fire_s = (cur_mode_s == MODE_NEVER) ? test_expr : ~test_expr;
          end else if (start_event) begin
            state_nxt_s = ST_ARMED;
            mode_nxt_s  = cur_mode_s;
            cnt_nxt_s   = num_cks;
          end else begin
            cnt_nxt_s = CNT_ZERO;
          end
        end
        ST_ARMED: begin
          case (mode_r)
            MODE_NEXT: begin
              if (check_s) begin
                fire_s      = ~test_expr;
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
              end else begin
                cnt_nxt_s = cnt_r - CNT_ONE;
              end
            end
            MODE_WINDOW: begin
              if (test_expr) begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
              end else if (check_s) begin
                fire_s      = 1'b1;
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
              end else begin
                cnt_nxt_s = cnt_r - CNT_ONE;
              end
            end
            default: begin
              state_nxt_s = ST_IDLE;
              cnt_nxt_s   = CNT_ZERO;
            end
          endcase
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, latched mode and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_NEXT;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      mode_r  <= mode_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/ovl_multi_checker.sv
// Multi-channel OVL checker: NUM_CH independent channels plus shared
// delayed/sticky failure flags, a saturating fire counter and config chaining.
module ovl_multi_checker
  import ovl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CKS_W  = DEF_CKS_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  ovl_multi_checker_if.slave bus
);

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NUM_CH-1:0] CH_ZERO  = {NUM_CH{1'b0}};

  logic [NUM_CH-1:0] fire_s;
  logic [NUM_CH-1:0] invalid_s;
  logic              any_fire_s;
  logic [NUM_CH-1:0] fire_delayed_r;
  logic [NUM_CH-1:0] fire_sticky_r;
  logic [CNT_W-1:0]  fire_count_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ovl_check_ch #(
      .CKS_W (CKS_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .enable      (bus.enable),
      .num_cks     (bus.num_cks[i*CKS_W +: CKS_W]),
      .start_event (bus.start_event[i]),
      .test_expr   (bus.test_expr[i]),
      .select      (bus.select[2*i +: 2]),
      .fire        (fire_s[i]),
      .invalid     (invalid_s[i])
    );
  end

  assign any_fire_s          = |fire_s;
  assign bus.fire            = fire_s;
  assign bus.any_fire        = any_fire_s;
  assign bus.config_invalid  = bus.prev_config_invalid | (|invalid_s);
  assign bus.fire_delayed    = fire_delayed_r;
  assign bus.fire_sticky     = fire_sticky_r;
  assign bus.fire_count      = fire_count_r;

  // One-cycle delayed copy of fire, frozen while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_delayed_r <= CH_ZERO;
    end else if (bus.enable) begin
      fire_delayed_r <= fire_s;
    end else begin
      fire_delayed_r <= fire_delayed_r;
    end
  end

  // Sticky failure flags; a fire in the clearing cycle keeps its bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_sticky_r <= CH_ZERO;
    end else if (bus.clear) begin
      fire_sticky_r <= fire_s;
    end else begin
      fire_sticky_r <= fire_sticky_r | fire_s;
    end
  end

  // Saturating count of cycles with any channel firing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_count_r <= CNT_ZERO;
    end else if (bus.clear) begin
      fire_count_r <= any_fire_s ? CNT_ONE : CNT_ZERO;
    end else if (any_fire_s && (fire_count_r != CNT_MAX)) begin
      fire_count_r <= fire_count_r + CNT_ONE;
    end else begin
      fire_count_r <= fire_count_r;
    end
  end

endmodule

// File: tb/tb_ovl_multi_checker.sv
// Table-driven bench for ovl_multi_checker: channel 0 is exercised through
// each mode while channels 1..3 sit idle in a valid NEXT configuration.
module tb_ovl_multi_checker;
  import ovl_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CKS_W  = 3;
  localparam int CNT_W  = 3;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  typedef struct {
    logic       en;
    logic       clr;
    logic [2:0] n;
    logic       st;
    logic       te;
    logic [1:0] sel;
    logic       pci;
    logic       f;
    logic       fd;
    logic       sk;
    logic [2:0] cnt;
    logic       ci;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];
  vec_t exp_q[$];

  ovl_multi_checker_if #(.NUM_CH(NUM_CH), .CKS_W(CKS_W), .CNT_W(CNT_W)) bus_if ();

  ovl_multi_checker #(
    .NUM_CH (NUM_CH),
    .CKS_W  (CKS_W),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic en, input logic clr, input logic [2:0] n,
                              input logic st, input logic te, input logic [1:0] sel,
                              input logic pci, input logic f, input logic fd,
                              input logic sk, input logic [2:0] cnt, input logic ci);
    vec_t v;
    v.en = en; v.clr = clr; v.n = n; v.st = st; v.te = te; v.sel = sel; v.pci = pci;
    v.f = f; v.fd = fd; v.sk = sk; v.cnt = cnt; v.ci = ci;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    bus_if.enable              = v.en;
    bus_if.clear               = v.clr;
    bus_if.num_cks             = {3'd3, 3'd3, 3'd3, v.n};
    bus_if.start_event         = {3'b000, v.st};
    bus_if.test_expr           = {3'b000, v.te};
    bus_if.select              = {6'b000000, v.sel};
    bus_if.prev_config_invalid = v.pci;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("row%0d fire", idx), 32'(bus_if.fire), 32'({3'b000, e.f}));
    chk($sformatf("row%0d any_fire", idx), 32'(bus_if.any_fire), 32'(e.f));
    chk($sformatf("row%0d fire_delayed", idx), 32'(bus_if.fire_delayed), 32'({3'b000, e.fd}));
    chk($sformatf("row%0d fire_sticky", idx), 32'(bus_if.fire_sticky), 32'({3'b000, e.sk}));
    chk($sformatf("row%0d fire_count", idx), 32'(bus_if.fire_count), 32'(e.cnt));
    chk($sformatf("row%0d config_invalid", idx), 32'(bus_if.config_invalid), 32'(e.ci));
  endtask

  initial begin
    vec_t idle_v;
    checks = 0;
    errors = 0;

    // NEXT pass, with a start while armed that must not restart the check
    add(H,L,3'd3,H,L,2'b00,L, L,L,L,3'd0,L);
    add(H,L,3'd3,H,L,2'b00,L, L,L,L,3'd0,L);
    add(H,L,3'd3,L,L,2'b00,L, L,L,L,3'd0,L);
    add(H,L,3'd3,L,H,2'b00,L, L,L,L,3'd0,L);
    add(H,L,3'd3,L,L,2'b00,L, L,L,L,3'd0,L);
    // NEXT fail; start during the check cycle is ignored
    add(H,L,3'd3,H,L,2'b00,L, L,L,L,3'd0,L);
    add(H,L,3'd3,L,L,2'b00,L, L,L,L,3'd0,L);
    add(H,L,3'd3,L,L,2'b00,L, L,L,L,3'd0,L);
    add(H,L,3'd3,H,L,2'b00,L, H,L,L,3'd0,L);
    add(H,L,3'd3,L,L,2'b00,L, L,H,H,3'd1,L);
    add(H,L,3'd3,L,L,2'b00,L, L,L,H,3'd1,L);
    add(H,L,3'd3,L,L,2'b00,L, L,L,H,3'd1,L);
    // WINDOW hit at t2, then a full window with test_expr low
    add(H,L,3'd4,H,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,L,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,L,H,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,L,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,L,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,H,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,L,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,L,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,L,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd4,L,L,2'b01,L, H,L,H,3'd1,L);
    add(H,L,3'd4,L,L,2'b01,L, L,H,H,3'd2,L);
    // invalid configuration, then ALWAYS with num_cks=0, then upstream invalid
    add(H,L,3'd0,H,L,2'b00,L, L,L,H,3'd2,H);
    add(H,L,3'd0,L,L,2'b00,L, L,L,H,3'd2,H);
    add(H,L,3'd0,L,L,2'b00,L, L,L,H,3'd2,H);
    add(H,L,3'd0,L,H,2'b10,L, L,L,H,3'd2,L);
    add(H,L,3'd0,L,L,2'b10,L, H,L,H,3'd2,L);
    add(H,L,3'd0,L,H,2'b10,L, L,H,H,3'd3,L);
    add(H,L,3'd3,L,H,2'b10,H, L,L,H,3'd3,H);
    // clear, then NEVER violated for 10 cycles to saturate the counter
    add(H,H,3'd3,L,L,2'b00,L, L,L,H,3'd3,L);
    add(H,L,3'd3,L,L,2'b00,L, L,L,L,3'd0,L);
    for (int k = 0; k < 10; k++) begin
      add(H,L,3'd3,L,H,2'b11,L, H, (k == 0) ? L : H, (k == 0) ? L : H,
          (k > 7) ? 3'd7 : 3'(k), L);
    end
    add(H,H,3'd3,L,H,2'b11,L, H,H,H,3'd7,L);
    add(H,L,3'd3,L,L,2'b11,L, L,H,H,3'd1,L);
    add(H,L,3'd3,L,L,2'b11,L, L,L,H,3'd1,L);
    // WINDOW stretched by two disabled cycles
    add(H,L,3'd3,H,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd3,L,L,2'b01,L, L,L,H,3'd1,L);
    add(L,L,3'd3,L,L,2'b01,L, L,L,H,3'd1,L);
    add(L,L,3'd3,L,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd3,L,L,2'b01,L, L,L,H,3'd1,L);
    add(H,L,3'd3,L,L,2'b01,L, H,L,H,3'd1,L);
    add(L,L,3'd3,L,L,2'b01,L, L,H,H,3'd2,L);
    add(L,L,3'd3,L,H,2'b11,L, L,H,H,3'd2,L);
    add(H,L,3'd3,L,L,2'b00,L, L,H,H,3'd2,L);
    // NEXT armed, to be aborted by reset
    add(H,L,3'd3,H,L,2'b00,L, L,L,H,3'd2,L);
    add(H,L,3'd3,L,L,2'b00,L, L,L,H,3'd2,L);

    // reset: registers zero and fire held low even with NEVER violated
    rst = 1'b1;
    idle_v = vecs[0];
    idle_v.st = L; idle_v.te = H; idle_v.sel = 2'b11;
    drive(idle_v);
    repeat (2) @(negedge clk);
    chk("reset fire", 32'(bus_if.fire), 32'd0);
    chk("reset any_fire", 32'(bus_if.any_fire), 32'd0);
    chk("reset fire_delayed", 32'(bus_if.fire_delayed), 32'd0);
    chk("reset fire_sticky", 32'(bus_if.fire_sticky), 32'd0);
    chk("reset fire_count", 32'(bus_if.fire_count), 32'd0);
    chk("reset config_invalid", 32'(bus_if.config_invalid), 32'd0);
    @(posedge clk);
    #1;
    idle_v.te = L; idle_v.sel = 2'b00;
    drive(idle_v);
    rst = 1'b0;

    foreach (vecs[i]) apply(i, vecs[i]);

    // t2 of the armed NEXT check: async reset mid-cycle
    @(posedge clk);
    #1;
    idle_v = vecs[0];
    idle_v.st = L;
    drive(idle_v);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset fire", 32'(bus_if.fire), 32'd0);
    chk("midreset fire_delayed", 32'(bus_if.fire_delayed), 32'd0);
    chk("midreset fire_sticky", 32'(bus_if.fire_sticky), 32'd0);
    chk("midreset fire_count", 32'(bus_if.fire_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("aborted check fire", 32'(bus_if.fire), 32'd0);
    idle_v.f = L; idle_v.fd = L; idle_v.sk = L; idle_v.cnt = 3'd0; idle_v.ci = L;
    apply(999, idle_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
